bike_orient_input: RTL and testbench

- Upstream front end that produces the four 32-bit orientation words fed into the processor's bike orientation inputs (one word per player, read via the decode stage).
- Per player, four raw direction buttons are synchronised, debounced and edge-detected, then converted to a registered orientation code.
- 180-degree reversals are rejected and requests are gated by the master run switch.
- Replaces the direct button-to-processor wiring.

---
 rtl/bike_orient_input.sv | 159 +++++++++++++++
 tb/tb_bike_orient_input.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bike_orient_input.sv
// Four-player button front end: sync, debounce, edge-detect and reversal-filter direction buttons into orientation words.
// Optional BIKE_TICK_ALIGN_EN defers accepted requests until a game-step tick.
module bike_orient_lane #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         CNT_W           = 20,
    parameter logic [1:0] RESET_CODE      = 2'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       masterSwitch,
`ifdef BIKE_TICK_ALIGN_EN
    input  logic       tick,
`endif
    input  logic [3:0] btnRaw,
    output logic [1:0] orient,
    output logic       changed
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]            sync1, sync2, deb, debPrev, rise;
    logic [3:0][CNT_W-1:0] cnt;
    logic                  reqVld, reqOk;
    logic [1:0]            reqCode;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            debPrev <= '0;
            cnt     <= '0;
        end else begin
            sync1   <= btnRaw;
            sync2   <= sync1;
            debPrev <= deb;
            for (int b = 0; b < 4; b++) begin
                if (sync2[b] == deb[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    deb[b] <= ~deb[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // Edge tracking runs while paused so a held button never fires on un-pause.
    assign rise = deb & ~debPrev;

    always_comb begin
        reqVld  = |rise;
        reqCode = 2'd0;
        if      (rise[0]) reqCode = 2'd0;
        else if (rise[1]) reqCode = 2'd1;
        else if (rise[2]) reqCode = 2'd2;
        else if (rise[3]) reqCode = 2'd3;
    end

    // Difference of 2 (mod 4) is a 180-degree reversal.
    assign reqOk = masterSwitch & reqVld & ((reqCode - orient) != 2'd2);

`ifdef BIKE_TICK_ALIGN_EN
    logic       pendVld, candOk;
    logic [1:0] pendCode, candCode;

    // A fresh request in the tick cycle wins over the older pending one.
    assign candCode = reqOk ? reqCode : pendCode;
    assign candOk   = (reqOk | pendVld) & ((candCode - orient) != 2'd2);

    always_ff @(posedge clock) begin
        if (reset) begin
            orient   <= RESET_CODE;
            changed  <= 1'b0;
            pendVld  <= 1'b0;
            pendCode <= 2'd0;
        end else begin
            changed <= 1'b0;
            if (tick) begin
                pendVld <= 1'b0;
                if (candOk && candCode != orient) begin
                    orient  <= candCode;
                    changed <= 1'b1;
                end
            end else if (reqOk) begin
                pendVld  <= 1'b1;
                pendCode <= reqCode;
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            orient  <= RESET_CODE;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (reqOk && reqCode != orient) begin
                orient  <= reqCode;
                changed <= 1'b1;
            end
        end
    end
`endif
endmodule

module bike_orient_input #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        masterSwitch,
`ifdef BIKE_TICK_ALIGN_EN
    input  logic        tick,
`endif
    input  logic [3:0]  btn_p1,
    input  logic [3:0]  btn_p2,
    input  logic [3:0]  btn_p3,
    input  logic [3:0]  btn_p4,
    output logic [31:0] bikeoneOrient_IN,
    output logic [31:0] biketwoOrient_IN,
    output logic [31:0] bikethreeOrient_IN,
    output logic [31:0] bikefourOrient_IN,
    output logic [3:0]  orient_changed
);
    localparam int NUM_LANES = 4;
    // Start headings: P1 right, P2 left, P3 down, P4 up.
    localparam logic [NUM_LANES-1:0][1:0] RST_CODES = {2'd0, 2'd2, 2'd3, 2'd1};

    logic [NUM_LANES-1:0][3:0] btnAll;
    logic [NUM_LANES-1:0][1:0] orientAll;

    assign btnAll = {btn_p4, btn_p3, btn_p2, btn_p1};

    for (genvar p = 0; p < NUM_LANES; p++) begin : gLane
        bike_orient_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RESET_CODE     (RST_CODES[p])
        ) uLane (
            .clock       (clock),
            .reset       (reset),
            .masterSwitch(masterSwitch),
`ifdef BIKE_TICK_ALIGN_EN
            .tick        (tick),
`endif
            .btnRaw      (btnAll[p]),
            .orient      (orientAll[p]),
            .changed     (orient_changed[p])
        );
    end

    assign bikeoneOrient_IN   = {30'd0, orientAll[0]};
    assign biketwoOrient_IN   = {30'd0, orientAll[1]};
    assign bikethreeOrient_IN = {30'd0, orientAll[2]};
    assign bikefourOrient_IN  = {30'd0, orientAll[3]};
endmodule

// File: tb/tb_bike_orient_input.sv
// Directed bench for bike_orient_input with DEBOUNCE_CYCLES=4.
module tb_bike_orient_input;
    logic        clock = 1'b0;
    logic        reset, masterSwitch;
    logic [3:0]  btn_p1, btn_p2, btn_p3, btn_p4;
    logic [31:0] o1, o2, o3, o4;
    logic [3:0]  orient_changed;
    int          nCmp = 0;
    int          nBad = 0;
`ifdef BIKE_TICK_ALIGN_EN
    logic        tick = 1'b1;
`endif

    bike_orient_input #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clock             (clock),
        .reset             (reset),
        .masterSwitch      (masterSwitch),
`ifdef BIKE_TICK_ALIGN_EN
        .tick              (tick),
`endif
        .btn_p1            (btn_p1),
        .btn_p2            (btn_p2),
        .btn_p3            (btn_p3),
        .btn_p4            (btn_p4),
        .bikeoneOrient_IN  (o1),
        .biketwoOrient_IN  (o2),
        .bikethreeOrient_IN(o3),
        .bikefourOrient_IN (o4),
        .orient_changed    (orient_changed)
    );

    always #5 clock = ~clock;

    task automatic run(input int n, output logic [3:0] seen);
        seen = '0;
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            seen |= orient_changed;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; masterSwitch = 1'b0;
        btn_p1 = '0; btn_p2 = '0; btn_p3 = '0; btn_p4 = '0;
        repeat (2) begin @(posedge clock); @(negedge clock); end
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        nCmp++; if (o1 !== 32'd1) begin nBad++; $display("FAIL reset_p1 got %0d want 1", o1); end
        nCmp++; if (o2 !== 32'd3) begin nBad++; $display("FAIL reset_p2 got %0d want 3", o2); end
        nCmp++; if (o3 !== 32'd2) begin nBad++; $display("FAIL reset_p3 got %0d want 2", o3); end
        nCmp++; if (o4 !== 32'd0) begin nBad++; $display("FAIL reset_p4 got %0d want 0", o4); end
        nCmp++; if (orient_changed !== 4'b0000) begin nBad++; $display("FAIL reset_chg got %b want 0000", orient_changed); end
    endtask

    task automatic test_glitch;
        logic [3:0] seen;
        masterSwitch = 1'b1;
        btn_p1 = 4'b0001;
        repeat (3) begin @(posedge clock); @(negedge clock); end
        btn_p1 = 4'b0000;
        run(12, seen);
        nCmp++; if (o1 !== 32'd1) begin nBad++; $display("FAIL glitch_p1 got %0d want 1", o1); end
        nCmp++; if (seen !== 4'b0000) begin nBad++; $display("FAIL glitch_chg got %b want 0000", seen); end
    endtask

    task automatic test_press_latency;
        logic [3:0] seen;
        btn_p1 = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock); @(negedge clock);
            nCmp++;
            if (o1 !== ((e >= 7) ? 32'd0 : 32'd1)) begin
                nBad++; $display("FAIL latency_p1 edge %0d got %0d want %0d", e, o1, (e >= 7) ? 0 : 1);
            end
            nCmp++;
            if (orient_changed !== ((e == 7) ? 4'b0001 : 4'b0000)) begin
                nBad++; $display("FAIL latency_chg edge %0d got %b want %b", e, orient_changed, (e == 7) ? 4'b0001 : 4'b0000);
            end
        end
        btn_p1 = 4'b0000;
        run(10, seen);
        nCmp++; if (seen !== 4'b0000) begin nBad++; $display("FAIL release_chg got %b want 0000", seen); end
    endtask

    task automatic test_reversal;
        logic [3:0] seen;
        btn_p2 = 4'b0010;
        run(10, seen);
        nCmp++; if (o2 !== 32'd3) begin nBad++; $display("FAIL rev_p2 got %0d want 3", o2); end
        nCmp++; if (seen !== 4'b0000) begin nBad++; $display("FAIL rev_chg got %b want 0000", seen); end
        btn_p2 = 4'b0000; run(10, seen);
        btn_p2 = 4'b0001;
        run(10, seen);
        nCmp++; if (o2 !== 32'd0) begin nBad++; $display("FAIL turn_p2 got %0d want 0", o2); end
        nCmp++; if (seen !== 4'b0010) begin nBad++; $display("FAIL turn_chg got %b want 0010", seen); end
        btn_p2 = 4'b0000; run(10, seen);
    endtask

    task automatic test_priority;
        logic [3:0] seen;
        btn_p3 = 4'b0101;
        run(10, seen);
        nCmp++; if (o3 !== 32'd2) begin nBad++; $display("FAIL prio_p3 got %0d want 2", o3); end
        nCmp++; if (seen !== 4'b0000) begin nBad++; $display("FAIL prio_chg got %b want 0000", seen); end
        btn_p3 = 4'b0000; run(10, seen);
    endtask

    task automatic test_pause;
        logic [3:0] seen;
        masterSwitch = 1'b0;
        btn_p4 = 4'b0010;
        run(10, seen);
        masterSwitch = 1'b1;
        run(10, seen);
        nCmp++; if (o4 !== 32'd0) begin nBad++; $display("FAIL pause_p4 got %0d want 0", o4); end
        nCmp++; if (seen !== 4'b0000) begin nBad++; $display("FAIL pause_chg got %b want 0000", seen); end
        btn_p4 = 4'b0000; run(10, seen);
        btn_p4 = 4'b0010;
        run(10, seen);
        nCmp++; if (o4 !== 32'd1) begin nBad++; $display("FAIL unpause_p4 got %0d want 1", o4); end
        nCmp++; if (seen !== 4'b1000) begin nBad++; $display("FAIL unpause_chg got %b want 1000", seen); end
        btn_p4 = 4'b0000; run(10, seen);
    endtask

    task automatic test_all_players;
        logic [3:0] seen;
        // From P1=0 P2=0 P3=2 P4=1: right, left, left, down are all legal.
        btn_p1 = 4'b0010; btn_p2 = 4'b1000; btn_p3 = 4'b1000; btn_p4 = 4'b0100;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clock); @(negedge clock);
            nCmp++;
            if (orient_changed !== ((e == 7) ? 4'b1111 : 4'b0000)) begin
                nBad++; $display("FAIL all_chg edge %0d got %b", e, orient_changed);
            end
        end
        nCmp++; if (o1 !== 32'd1) begin nBad++; $display("FAIL all_p1 got %0d want 1", o1); end
        nCmp++; if (o2 !== 32'd3) begin nBad++; $display("FAIL all_p2 got %0d want 3", o2); end
        nCmp++; if (o3 !== 32'd3) begin nBad++; $display("FAIL all_p3 got %0d want 3", o3); end
        nCmp++; if (o4 !== 32'd2) begin nBad++; $display("FAIL all_p4 got %0d want 2", o4); end
        btn_p1 = '0; btn_p2 = '0; btn_p3 = '0; btn_p4 = '0;
        run(10, seen);
    endtask

    task automatic test_same_code;
        logic [3:0] seen;
        btn_p1 = 4'b0010;
        run(10, seen);
        nCmp++; if (o1 !== 32'd1) begin nBad++; $display("FAIL same_p1 got %0d want 1", o1); end
        nCmp++; if (seen !== 4'b0000) begin nBad++; $display("FAIL same_chg got %b want 0000", seen); end
        btn_p1 = 4'b0000; run(10, seen);
    endtask

    task automatic test_reset_mid;
        logic [3:0] seen;
        btn_p1 = 4'b0001;
        run(4, seen);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        nCmp++; if (o1 !== 32'd1) begin nBad++; $display("FAIL midrst_p1 got %0d want 1", o1); end
        nCmp++; if (o2 !== 32'd3) begin nBad++; $display("FAIL midrst_p2 got %0d want 3", o2); end
        nCmp++; if (o3 !== 32'd2) begin nBad++; $display("FAIL midrst_p3 got %0d want 2", o3); end
        nCmp++; if (o4 !== 32'd0) begin nBad++; $display("FAIL midrst_p4 got %0d want 0", o4); end
        run(12, seen);
        nCmp++; if (o1 !== 32'd0) begin nBad++; $display("FAIL redeb_p1 got %0d want 0", o1); end
        nCmp++; if (seen !== 4'b0001) begin nBad++; $display("FAIL redeb_chg got %b want 0001", seen); end
        btn_p1 = 4'b0000; run(10, seen);
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_press_latency;
        test_reversal;
        test_priority;
        test_pause;
        test_all_players;
        test_same_code;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
